// File: rtl/seven_seg_pkg.sv
// Shared seven-segment code table, blank code, decoded-digit record and scan FSM encoding.
package seven_seg_pkg;

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned CNT_W    = 4;

    // Segment codes, bit0 = a ... bit6 = g, active-high
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F = 7'h71;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    typedef struct packed {
        logic [NIBBLE_W-1:0] nibble;
        logic                legal;
        logic                blank;
    } seg_dec_t;

    // Forward table used by both the encoder and the inverse lookup
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] n);
        logic [SEG_W-1:0] s;
        case (n)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_segment_to_binary.sv
// Combinational inverse lookup of a segment pattern to {nibble, legal, blank}.
module seven_segment_to_binary
    import seven_seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output seg_dec_t         dec
);

    // Search the shared forward table so both directions cannot drift apart
    always_comb begin
        dec.nibble = '0;
        dec.legal  = 1'b0;
        dec.blank  = (seg == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (seg == hex_to_seg(NIBBLE_W'(i))) begin
                dec.nibble = NIBBLE_W'(i);
                dec.legal  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Sniffs a multiplexed 7-segment bus and rebuilds the displayed hex value.
// Optional decimal-point capture enabled by SEVEN_SEG_DECIMAL_POINT_EN.
module seven_segment_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter  int unsigned NUM_DIGITS    = 4,
    parameter  int unsigned STABLE_CYCLES = 4,
    localparam int unsigned IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SEG_W-1:0]        seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
`ifdef SEVEN_SEG_DECIMAL_POINT_EN
    input  logic                    dp_in,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic                    value_valid,
    output logic                    update,
    output logic                    digit_err,
    output logic [IDX_W-1:0]        err_digit
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0]      seg_s1, seg_s2, seg_prev;
    logic [NUM_DIGITS-1:0] an_s1, an_s2, an_prev;
`ifdef SEVEN_SEG_DECIMAL_POINT_EN
    logic                  dp_s1, dp_s2, dp_prev;
`endif

    logic [CNT_W-1:0]      cnt, cnt_nxt;
    state_t                state, state_nxt;
    logic [NUM_DIGITS-1:0] mask;
    logic [NUM_DIGITS-1:0] sel;
    logic                  one_hot;
    logic [IDX_W-1:0]      idx;
    logic                  changed;
    logic                  capture;
    logic                  wr_en, err_en;
    seg_dec_t              dec;

    seven_segment_to_binary u_dec (
        .seg (seg_s2),
        .dec (dec)
    );

    // Two-flop synchronizer plus one-cycle history for the stability compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1   <= '0;
            seg_s2   <= '0;
            seg_prev <= '0;
            an_s1    <= '0;
            an_s2    <= '0;
            an_prev  <= '0;
`ifdef SEVEN_SEG_DECIMAL_POINT_EN
            dp_s1    <= 1'b0;
            dp_s2    <= 1'b0;
            dp_prev  <= 1'b0;
`endif
        end else begin
            seg_s1   <= seg_in;
            seg_s2   <= seg_s1;
            seg_prev <= seg_s2;
            an_s1    <= an_in;
            an_s2    <= an_s1;
            an_prev  <= an_s2;
`ifdef SEVEN_SEG_DECIMAL_POINT_EN
            dp_s1    <= dp_in;
            dp_s2    <= dp_s1;
            dp_prev  <= dp_s2;
`endif
        end
    end

    // Strobe qualification: exactly one anode low, and which one
    always_comb begin
        sel     = ~an_s2;
        one_hot = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
        idx     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s2[i]) idx = IDX_W'(i);
        end
`ifdef SEVEN_SEG_DECIMAL_POINT_EN
        changed = (seg_s2 != seg_prev) || (an_s2 != an_prev) || (dp_s2 != dp_prev);
`else
        changed = (seg_s2 != seg_prev) || (an_s2 != an_prev);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, saturating stability counter and capture strobes
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        if (changed)               cnt_nxt = '0;
        else if (cnt == CNT_MAX)   cnt_nxt = cnt;
        else                       cnt_nxt = cnt + CNT_W'(1);

        case (state)
            ST_IDLE: begin
                if (one_hot) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!one_hot) begin
                    state_nxt = ST_IDLE;
                end else if (!changed && (cnt == CNT_MAX)) begin
                    capture   = 1'b1;
                    state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (changed) state_nxt = one_hot ? ST_SETTLE : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        wr_en  = capture && dec.legal;
        err_en = capture && !dec.legal && !dec.blank;
    end

    // Digit registers, capture mask and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_out   <= '0;
            value_valid <= 1'b0;
            update      <= 1'b0;
            digit_err   <= 1'b0;
            err_digit   <= '0;
            mask        <= '0;
        end else begin
            update    <= wr_en;
            digit_err <= err_en;
            if (err_en) err_digit <= idx;
            if (wr_en) begin
                mask <= mask | sel;
                if (&(mask | sel)) value_valid <= 1'b1;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx == IDX_W'(i)) value_out[4*i +: 4] <= dec.nibble;
                end
            end
        end
    end

`ifdef SEVEN_SEG_DECIMAL_POINT_EN
    // Decimal point follows every non-illegal capture of its digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_out <= '0;
        end else if (capture && (dec.legal || dec.blank)) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx == IDX_W'(i)) dp_out[i] <= dp_s2;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed table-driven bench for seven_segment_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seven_segment_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] value_out;
    logic        value_valid;
    logic        update;
    logic        digit_err;
    logic [1:0]  err_digit;
`ifdef SEVEN_SEG_DECIMAL_POINT_EN
    logic        dp_in = 1'b0;
    logic [3:0]  dp_out;
`endif

    seven_segment_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
`ifdef SEVEN_SEG_DECIMAL_POINT_EN
        .dp_in       (dp_in),
        .dp_out      (dp_out),
`endif
        .value_out   (value_out),
        .value_valid (value_valid),
        .update      (update),
        .digit_err   (digit_err),
        .err_digit   (err_digit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int upd_total = 0;
    int err_total = 0;
    int last_upd = 0;
    int last_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && update) begin
            upd_total = upd_total + 1;
            last_upd  = cyc;
        end
        if (rst_n && digit_err) begin
            err_total = err_total + 1;
            last_err  = cyc;
        end
    end

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        int          upd;
        int          err;
        logic [15:0] val;
        logic        valid;
        logic [1:0]  edig;
    } vec_t;

    vec_t tbl [11];
    int   n_chk = 0;
    int   n_bad = 0;
    int   t0;

    // Edge 0 of the strobe is cyc == t0+1; capture registered at edge 6 -> cyc == t0+7
    localparam int LAT = 7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Caller is just after a posedge; strobe lasts 'hold' edges, then an idle gap
    task automatic strobe(input logic [3:0] an, input logic [6:0] seg, input int hold);
        an_in  = an;
        seg_in = seg;
        t0     = cyc;
        repeat (hold) @(posedge clk);
        #1;
        an_in  = 4'hF;
        seg_in = 7'h00;
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        int u0, e0;
        tbl[0]  = '{4'b1110, 7'h4F,  8, 1, 0, 16'h0003, 1'b0, 2'd0};
        tbl[1]  = '{4'b1101, 7'h77,  8, 1, 0, 16'h00A3, 1'b0, 2'd0};
        tbl[2]  = '{4'b1011, 7'h7C,  8, 1, 0, 16'h0BA3, 1'b0, 2'd0};
        tbl[3]  = '{4'b0111, 7'h3F,  8, 1, 0, 16'h0BA3, 1'b1, 2'd0};
        tbl[4]  = '{4'b1110, 7'h06,  4, 0, 0, 16'h0BA3, 1'b1, 2'd0};
        tbl[5]  = '{4'b1110, 7'h06,  5, 1, 0, 16'h0BA1, 1'b1, 2'd0};
        tbl[6]  = '{4'b1101, 7'h01,  8, 0, 1, 16'h0BA1, 1'b1, 2'd1};
        tbl[7]  = '{4'b1100, 7'h3F,  8, 0, 0, 16'h0BA1, 1'b1, 2'd1};
        tbl[8]  = '{4'b1111, 7'h3F,  8, 0, 0, 16'h0BA1, 1'b1, 2'd1};
        tbl[9]  = '{4'b1011, 7'h00,  8, 0, 0, 16'h0BA1, 1'b1, 2'd1};
        tbl[10] = '{4'b0111, 7'h5B, 20, 1, 0, 16'h2BA1, 1'b1, 2'd1};

        rst_n  = 1'b0;
        an_in  = 4'hF;
        seg_in = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset value_out",   32'(value_out),   32'h0);
        chk("reset value_valid", 32'(value_valid), 32'h0);
        chk("reset update",      32'(update),      32'h0);
        chk("reset digit_err",   32'(digit_err),   32'h0);
        chk("reset err_digit",   32'(err_digit),   32'h0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int v = 0; v < 11; v++) begin
            u0 = upd_total;
            e0 = err_total;
            strobe(tbl[v].an, tbl[v].seg, tbl[v].hold);
            chk($sformatf("v%0d update count", v), 32'(upd_total - u0), 32'(tbl[v].upd));
            chk($sformatf("v%0d err count", v),    32'(err_total - e0), 32'(tbl[v].err));
            chk($sformatf("v%0d value_out", v),    32'(value_out),      32'(tbl[v].val));
            chk($sformatf("v%0d value_valid", v),  32'(value_valid),    32'(tbl[v].valid));
            chk($sformatf("v%0d err_digit", v),    32'(err_digit),      32'(tbl[v].edig));
            if (tbl[v].upd == 1)
                chk($sformatf("v%0d update latency", v), 32'(last_upd - t0), 32'(LAT));
            if (tbl[v].err == 1)
                chk($sformatf("v%0d err latency", v), 32'(last_err - t0), 32'(LAT));
        end

        // Two captures, then an asynchronous reset between clock edges
        strobe(4'b1110, 7'h06, 8);
        strobe(4'b1101, 7'h5B, 8);
        chk("pre-reset value_out", 32'(value_out), 32'h2B21);
        rst_n = 1'b0;
        #2;
        chk("async reset value_out",   32'(value_out),   32'h0);
        chk("async reset value_valid", 32'(value_valid), 32'h0);
        chk("async reset err_digit",   32'(err_digit),   32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Three digits are not enough to restore value_valid
        strobe(4'b1110, 7'h7D, 8);
        strobe(4'b1101, 7'h07, 8);
        strobe(4'b1011, 7'h7F, 8);
        chk("rescan partial value_out",   32'(value_out),   32'h0876);
        chk("rescan partial value_valid", 32'(value_valid), 32'h0);
        strobe(4'b0111, 7'h6F, 8);
        chk("rescan full value_out",   32'(value_out),   32'h9876);
        chk("rescan full value_valid", 32'(value_valid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
